// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Sequencer sitting directly in front of the 32 x 64-bit data memory.
// It accepts one load/store request at a time from the execute stage and
// computes the effective byte address (base + sign-extended 12-bit offset).
// It rejects out-of-range, misaligned and illegal-size requests. It drives
// the memory word address, write enable and write data. Stores narrower than
// a doubleword use read-modify-write. The unit returns sign- or zero-extended
// load data with a one-cycle response pulse.
//
// Ports
//   i_clk          rising-edge clock shared with the data memory
//   i_rst_n        synchronous active-low reset
//   i_req_valid    request present
//   o_req_ready    unit idle and able to accept a request
//   i_req_store    1 = store, 0 = load
//   i_req_funct3   RISC-V size/sign encoding
//   i_req_base     base register value
//   i_req_offset   signed 12-bit immediate
//   i_req_wdata    store data (low bytes used for sub-word sizes)
//   o_resp_valid   one-cycle completion pulse
//   o_resp_data    extended load result, 0 for stores and errors
//   o_resp_err     request rejected (qualified by o_resp_valid)
//   o_mem_addr     memory word index, held from acceptance through response
//   o_mem_we       memory write enable
//   o_mem_din      memory write data (0 outside the write cycle)
//   i_mem_dout     memory read data (valid the cycle after the address)
// -----------------------------------------------------------------------------
module load_store_unit (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_store,
  input  logic [2:0]  i_req_funct3,
  input  logic [63:0] i_req_base,
  input  logic [11:0] i_req_offset,
  input  logic [63:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [63:0] o_resp_data,
  output logic        o_resp_err,
  output logic [4:0]  o_mem_addr,
  output logic        o_mem_we,
  output logic [63:0] o_mem_din,
  input  logic [63:0] i_mem_dout
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_t;

  // Select the addressed bytes of a doubleword and extend them to 64 bits
  // according to the load encoding.
  function automatic logic [63:0] extract_load(input logic [63:0] word,
                                               input logic [2:0]  lane,
                                               input logic [2:0]  funct3);
    logic [63:0] shifted;
    shifted = word >> {lane, 3'b000};
    case (funct3)
      3'b000:  extract_load = {{56{shifted[7]}},  shifted[7:0]};
      3'b001:  extract_load = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  extract_load = {{32{shifted[31]}}, shifted[31:0]};
      3'b011:  extract_load = shifted;
      3'b100:  extract_load = {56'd0, shifted[7:0]};
      3'b101:  extract_load = {48'd0, shifted[15:0]};
      3'b110:  extract_load = {32'd0, shifted[31:0]};
      default: extract_load = 64'd0;
    endcase
  endfunction

  // Replace the bytes covered by a store of the given size at the given lane
  // with the low bytes of the store data, keeping the rest of the old word.
  function automatic logic [63:0] merge_store(input logic [63:0] old_word,
                                              input logic [63:0] wdata,
                                              input logic [2:0]  lane,
                                              input logic [1:0]  size);
    logic [63:0] mask;
    logic [5:0]  shamt;
    shamt = {lane, 3'b000};
    case (size)
      2'b00:   mask = 64'h0000_0000_0000_00FF;
      2'b01:   mask = 64'h0000_0000_0000_FFFF;
      2'b10:   mask = 64'h0000_0000_FFFF_FFFF;
      default: mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    mask        = mask << shamt;
    merge_store = (old_word & ~mask) | ((wdata << shamt) & mask);
  endfunction

  // Registered state and request context
  state_t      r_state;
  logic        r_store;
  logic [2:0]  r_funct3;
  logic [63:0] r_wdata;
  logic [2:0]  r_lane;
  logic [4:0]  r_addr;
  logic [63:0] r_rdata;
  logic [63:0] r_resp_data;
  logic        r_resp_err;

  // Combinational helpers
  state_t      w_next;
  logic [63:0] w_ea;
  logic        w_range_err;
  logic        w_misalign;
  logic        w_illegal;
  logic        w_req_err;
  logic        w_accept;
  logic        w_is_sd;
  logic        w_resp_load;
  logic [63:0] w_resp_data_d;
  logic        w_resp_err_d;
  logic [63:0] w_load_data;
  logic [63:0] w_wr_data;

  // Effective address wraps modulo 2^64; only 0x00-0xFF is backed by memory.
  assign w_ea        = i_req_base + {{52{i_req_offset[11]}}, i_req_offset};
  assign w_range_err = |w_ea[63:8];
  assign w_illegal   = i_req_store ? i_req_funct3[2] : (i_req_funct3 == 3'b111);
  assign w_req_err   = w_range_err | w_misalign | w_illegal;
  assign w_is_sd     = i_req_store & (i_req_funct3 == 3'b011);

  // Ready is suppressed while reset is held so nothing is accepted then.
  assign o_req_ready = i_rst_n & (r_state == S_IDLE);
  assign w_accept    = i_req_valid & o_req_ready;

  // Alignment check; funct3[1:0] is the access size for every legal encoding.
  always_comb begin
    w_misalign = 1'b0;
    case (i_req_funct3[1:0])
      2'b00:   w_misalign = 1'b0;
      2'b01:   w_misalign = w_ea[0];
      2'b10:   w_misalign = |w_ea[1:0];
      2'b11:   w_misalign = |w_ea[2:0];
      default: w_misalign = 1'b0;
    endcase
  end

  // Load result is taken straight from the memory output in the capture cycle
  // so it is ready on the first response cycle. Word 0 always reads as zero.
  always_comb begin
    if (r_addr == 5'd0) begin
      w_load_data = 64'd0;
    end else begin
      w_load_data = extract_load(i_mem_dout, r_lane, r_funct3);
    end
  end

  // Write data: full doubleword for SD, otherwise the merged captured word.
  always_comb begin
    if (r_funct3[1:0] == 2'b11) begin
      w_wr_data = r_wdata;
    end else begin
      w_wr_data = merge_store(r_rdata, r_wdata, r_lane, r_funct3[1:0]);
    end
  end

  // Next-state logic and response-register load enables
  always_comb begin
    w_next        = r_state;
    w_resp_load   = 1'b0;
    w_resp_data_d = 64'd0;
    w_resp_err_d  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_req_err) begin
            w_next       = S_RESP;
            w_resp_load  = 1'b1;
            w_resp_err_d = 1'b1;
          end else if (w_is_sd) begin
            w_next = S_WR;
          end else begin
            w_next = S_RD;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_RD: begin
        w_next = S_CAP;
      end
      S_CAP: begin
        if (r_store) begin
          w_next = S_WR;
        end else begin
          w_next        = S_RESP;
          w_resp_load   = 1'b1;
          w_resp_data_d = w_load_data;
        end
      end
      S_WR: begin
        w_next      = S_RESP;
        w_resp_load = 1'b1;
      end
      S_RESP: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Request context, captured read data and response registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_store     <= 1'b0;
      r_funct3    <= 3'd0;
      r_wdata     <= 64'd0;
      r_lane      <= 3'd0;
      r_addr      <= 5'd0;
      r_rdata     <= 64'd0;
      r_resp_data <= 64'd0;
      r_resp_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_store  <= i_req_store;
        r_funct3 <= i_req_funct3;
        r_wdata  <= i_req_wdata;
        r_lane   <= w_ea[2:0];
        r_addr   <= w_ea[7:3];
      end
      if (r_state == S_CAP) begin
        r_rdata <= i_mem_dout;
      end
      if (w_resp_load) begin
        r_resp_data <= w_resp_data_d;
        r_resp_err  <= w_resp_err_d;
      end
    end
  end

  assign o_resp_valid = (r_state == S_RESP);
  assign o_resp_data  = r_resp_data;
  assign o_resp_err   = r_resp_err;
  assign o_mem_addr   = r_addr;
  // Write enable is gated by reset so a write cycle overlapping reset is lost.
  assign o_mem_we     = i_rst_n & (r_state == S_WR);
  assign o_mem_din    = (r_state == S_WR) ? w_wr_data : 64'd0;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_D  = 3'b011;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;
  localparam logic [2:0] F_WU = 3'b110;
  localparam logic [2:0] F_X  = 3'b111;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_base;
  logic [11:0] req_offset;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        resp_err;
  logic [4:0]  mem_addr;
  logic        mem_we;
  logic [63:0] mem_din;
  logic [63:0] mem_dout;

  logic [63:0] mem [32];

  int checks = 0;
  int errors = 0;

  load_store_unit dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_store  (req_store),
    .i_req_funct3 (req_funct3),
    .i_req_base   (req_base),
    .i_req_offset (req_offset),
    .i_req_wdata  (req_wdata),
    .o_resp_valid (resp_valid),
    .o_resp_data  (resp_data),
    .o_resp_err   (resp_err),
    .o_mem_addr   (mem_addr),
    .o_mem_we     (mem_we),
    .o_mem_din    (mem_din),
    .i_mem_dout   (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory model: synchronous read, word 0 reads zero and ignores writes.
  always @(posedge clk) begin
    if (mem_we && mem_addr != 5'd0) mem[mem_addr] <= mem_din;
    mem_dout <= (mem_addr == 5'd0) ? 64'd0 : mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request and observe it until the response (bounded).
  task automatic run_req(input string tag, input logic st, input logic [2:0] f3,
                         input logic [63:0] base, input logic [11:0] off, input logic [63:0] wd,
                         output logic [63:0] rdata, output logic rerr, output int rcyc,
                         output int wcnt, output int wcyc, output logic [4:0] waddr,
                         output logic [63:0] wdin);
    rdata = 64'd0; rerr = 1'b0; rcyc = -1; wcnt = 0; wcyc = -1; waddr = 5'd0; wdin = 64'd0;
    chk({tag, "_ready"}, {63'd0, req_ready}, 64'd1);
    req_store = st; req_funct3 = f3; req_base = base; req_offset = off; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (mem_we) begin wcnt++; wcyc = c; waddr = mem_addr; wdin = mem_din; end
      if (resp_valid) begin rcyc = c; rdata = resp_data; rerr = resp_err; break; end
      @(posedge clk); #1;
    end
    if (rcyc >= 0) begin
      @(posedge clk); #1;
      chk({tag, "_pulse_end"}, {63'd0, resp_valid}, 64'd0);
    end
  endtask

  task automatic txn(input string tag, input logic st, input logic [2:0] f3,
                     input logic [63:0] base, input logic [11:0] off, input logic [63:0] wd,
                     input logic [63:0] e_data, input logic e_err, input int e_cyc,
                     input int e_wcnt, input int e_wcyc, input logic [4:0] e_waddr,
                     input logic [63:0] e_wdin);
    logic [63:0] rdata; logic rerr; int rcyc; int wcnt; int wcyc;
    logic [4:0] waddr; logic [63:0] wdin;
    run_req(tag, st, f3, base, off, wd, rdata, rerr, rcyc, wcnt, wcyc, waddr, wdin);
    chk({tag, "_data"}, rdata, e_data);
    chk({tag, "_err"}, {63'd0, rerr}, {63'd0, e_err});
    chk({tag, "_latency"}, 64'(rcyc), 64'(e_cyc));
    chk({tag, "_we_count"}, 64'(wcnt), 64'(e_wcnt));
    if (e_wcnt != 0) begin
      chk({tag, "_we_cycle"}, 64'(wcyc), 64'(e_wcyc));
      chk({tag, "_we_addr"}, {59'd0, waddr}, {59'd0, e_waddr});
      chk({tag, "_we_din"}, wdin, e_wdin);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
    req_base = 64'd0; req_offset = 12'd0; req_wdata = 64'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {63'd0, req_ready}, 64'd0);
    chk("rst_we", {63'd0, mem_we}, 64'd0);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_err", {63'd0, resp_err}, 64'd0);
    chk("rst_resp_data", resp_data, 64'd0);
    chk("rst_mem_addr", {59'd0, mem_addr}, 64'd0);
    chk("rst_mem_din", mem_din, 64'd0);
    rst_n = 1'b1; #1;
    chk("rst_release_ready", {63'd0, req_ready}, 64'd1);
    @(posedge clk); #1;

    // Preload word 3 through an SD, then read it back
    txn("sd_w3", 1'b1, F_D, 64'h18, 12'h000, 64'h8877665544332211,
        64'd0, 1'b0, 2, 1, 1, 5'd3, 64'h8877665544332211);
    txn("ld_w3", 1'b0, F_D, 64'h10, 12'h008, 64'd0,
        64'h8877665544332211, 1'b0, 3, 0, 0, 5'd0, 64'd0);

    // Sub-word load extraction
    txn("lb_1f", 1'b0, F_B, 64'h1F, 12'h000, 64'd0, 64'hFFFFFFFFFFFFFF88, 1'b0, 3, 0, 0, 5'd0, 64'd0);
    txn("lbu_1f", 1'b0, F_BU, 64'h1F, 12'h000, 64'd0, 64'h0000000000000088, 1'b0, 3, 0, 0, 5'd0, 64'd0);
    txn("lh_1e", 1'b0, F_H, 64'h1E, 12'h000, 64'd0, 64'hFFFFFFFFFFFF8877, 1'b0, 3, 0, 0, 5'd0, 64'd0);
    txn("lw_1c", 1'b0, F_W, 64'h1C, 12'h000, 64'd0, 64'hFFFFFFFF88776655, 1'b0, 3, 0, 0, 5'd0, 64'd0);
    txn("lwu_1c", 1'b0, F_WU, 64'h1C, 12'h000, 64'd0, 64'h0000000088776655, 1'b0, 3, 0, 0, 5'd0, 64'd0);
    txn("lb_19", 1'b0, F_B, 64'h19, 12'h000, 64'd0, 64'h0000000000000022, 1'b0, 3, 0, 0, 5'd0, 64'd0);

    // Read-modify-write byte store, upper data bits must be ignored
    txn("sb_1a", 1'b1, F_B, 64'h1A, 12'h000, 64'h123456789ABCDEAB,
        64'd0, 1'b0, 4, 1, 3, 5'd3, 64'h8877665544AB2211);
    txn("ld_after_sb", 1'b0, F_D, 64'h18, 12'h000, 64'd0,
        64'h8877665544AB2211, 1'b0, 3, 0, 0, 5'd0, 64'd0);

    // Error cases: misaligned, out of range, illegal encodings
    txn("lw_misal", 1'b0, F_W, 64'h1A, 12'h000, 64'd0, 64'd0, 1'b1, 1, 0, 0, 5'd0, 64'd0);
    txn("ld_range", 1'b0, F_D, 64'hF8, 12'h008, 64'd0, 64'd0, 1'b1, 1, 0, 0, 5'd0, 64'd0);
    txn("ld_illegal", 1'b0, F_X, 64'h18, 12'h000, 64'd0, 64'd0, 1'b1, 1, 0, 0, 5'd0, 64'd0);
    txn("st_illegal", 1'b1, F_BU, 64'h18, 12'h000, 64'hFF, 64'd0, 1'b1, 1, 0, 0, 5'd0, 64'd0);

    // Word 0 is constant zero
    txn("sd_w0", 1'b1, F_D, 64'h00, 12'h000, 64'hFFFFFFFFFFFFFFFF,
        64'd0, 1'b0, 2, 1, 1, 5'd0, 64'hFFFFFFFFFFFFFFFF);
    txn("ld_w0", 1'b0, F_D, 64'h00, 12'h000, 64'd0, 64'd0, 1'b0, 3, 0, 0, 5'd0, 64'd0);

    // Negative offset
    txn("ld_negoff", 1'b0, F_D, 64'h20, 12'hFF8, 64'd0,
        64'h8877665544AB2211, 1'b0, 3, 0, 0, 5'd0, 64'd0);

    // Halfword store at lane 4, then signed/unsigned halfword loads
    txn("sh_1c", 1'b1, F_H, 64'h1C, 12'h000, 64'h000000000000BEEF,
        64'd0, 1'b0, 4, 1, 3, 5'd3, 64'h8877BEEF44AB2211);
    txn("lhu_1c", 1'b0, F_HU, 64'h1C, 12'h000, 64'd0, 64'h000000000000BEEF, 1'b0, 3, 0, 0, 5'd0, 64'd0);
    txn("lh_1c", 1'b0, F_H, 64'h1C, 12'h000, 64'd0, 64'hFFFFFFFFFFFFBEEF, 1'b0, 3, 0, 0, 5'd0, 64'd0);

    // Reset asserted during the write cycle of an SB
    req_store = 1'b1; req_funct3 = F_B; req_base = 64'h18; req_offset = 12'h000;
    req_wdata = 64'h0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstwr_we_before", {63'd0, mem_we}, 64'd1);
    rst_n = 1'b0; #1;
    chk("rstwr_we_gated", {63'd0, mem_we}, 64'd0);
    chk("rstwr_ready_low", {63'd0, req_ready}, 64'd0);
    @(posedge clk); #1;
    chk("rstwr_no_resp", {63'd0, resp_valid}, 64'd0);
    rst_n = 1'b1; #1;
    chk("rstwr_ready_after", {63'd0, req_ready}, 64'd1);
    @(posedge clk); #1;
    chk("rstwr_still_no_resp", {63'd0, resp_valid}, 64'd0);
    txn("ld_after_rst", 1'b0, F_D, 64'h18, 12'h000, 64'd0,
        64'h8877BEEF44AB2211, 1'b0, 3, 0, 0, 5'd0, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
